// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a writing stage targets a live (nonzero) source register.
  function automatic logic src_match(input logic [4:0] src,
                                     input logic [4:0] rd,
                                     input logic       wr);
    return wr && (rd == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select; EX/MEM wins over MEM/WB, r0 never forwarded.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd,
                                         input logic       m_wr,
                                         input logic [4:0] w_rd,
                                         input logic       w_wr);
    if (src_match(src, m_rd, m_wr)) return FWD_EXMEM;
    if (src_match(src, w_rd, w_wr)) return FWD_MEMWB;
    return FWD_REGFILE;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b = fwd_sel(rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipeline.
// Define PIPELINE_HAZARD_CTRL_FORWARD_EN to enable operand forwarding; otherwise RAW hazards stall.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_to_reg,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_reg_write,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_reg_write,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   memwb_bubble,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_err
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     mem_err_q, mem_err_d;
  logic                     hazard;
  logic [1:0]               fu_a, fu_b;

  // A load in EX cannot forward in time, so its consumer in ID must wait one cycle.
  always_comb begin
    hazard = ex_mem_to_reg &&
             (src_match(id_rs, ex_rd, 1'b1) ||
              (id_uses_rt && src_match(id_rt, ex_rd, 1'b1)));
`ifndef PIPELINE_HAZARD_CTRL_FORWARD_EN
    hazard = hazard ||
             src_match(id_rs, ex_rd, ex_reg_write) ||
             src_match(id_rs, mem_rd, mem_reg_write) ||
             (id_uses_rt && (src_match(id_rt, ex_rd, ex_reg_write) ||
                             src_match(id_rt, mem_rd, mem_reg_write)));
`endif
  end

`ifdef PIPELINE_HAZARD_CTRL_FORWARD_EN
  forward_unit u_forward_unit (
    .rs            (id_rs),
    .rt            (id_rt),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fu_a),
    .fwd_b         (fu_b)
  );
  logic unused_fwd_en;
  assign unused_fwd_en = ex_reg_write;
`else
  assign fu_a = FWD_REGFILE;
  assign fu_b = FWD_REGFILE;
  logic unused_fwd_dis;
  assign unused_fwd_dis = ^{wb_rd, wb_reg_write};
`endif

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;

    if (!dmem_ready && (state_q == MEM_WAIT || dmem_req)) begin
      // Memory hold freezes everything, including a branch sitting in EX.
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      memwb_bubble = 1'b1;
      state_d      = MEM_WAIT;
      if (state_q == RUN) wait_cnt_d = WAIT_W'(1);
      else if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      if ((MEM_TIMEOUT > 0) && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT))) mem_err_d = 1'b1;
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end

    stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign fwd_a       = rst_n ? fu_a : FWD_REGFILE;
  assign fwd_b       = rst_n ? fu_b : FWD_REGFILE;
  assign stall_count = stall_cnt_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases plus randomized traffic vs a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int SW = 4;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rt, ex_reg_write, ex_mem_to_reg, mem_reg_write, wb_reg_write;
  logic          branch_taken, dmem_req, dmem_ready;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [SW-1:0] stall_count;
  logic          mem_err;

  int checks = 0;
  int errors = 0;

  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_stalls;

  pipeline_hazard_ctrl #(.STALL_CNT_W(SW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Does the ID instruction have to wait for a producer still in flight?
  function automatic bit model_hazard();
    logic [4:0] srcs [2];
    srcs[0] = id_rs;
    srcs[1] = id_uses_rt ? id_rt : 5'd0;
    for (int i = 0; i < 2; i++) begin
      if (srcs[i] != 5'd0) begin
        if (ex_mem_to_reg && ex_rd == srcs[i]) return 1'b1;
`ifndef PIPELINE_HAZARD_CTRL_FORWARD_EN
        if (ex_reg_write && ex_rd == srcs[i]) return 1'b1;
        if (mem_reg_write && mem_rd == srcs[i]) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef PIPELINE_HAZARD_CTRL_FORWARD_EN
    if (src == 5'd0) return 2'b00;
    if (mem_reg_write && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  // Per-cycle compare; control bits packed as {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush,bubble}.
  always @(negedge clk) begin
    logic [7:0] exp_ctl;
    bit hold;
    if (!rst_n) begin
      chk("rst_ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble}, 8'b00000111);
      chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
      chk("rst_stall", stall_count, 0);
      chk("rst_err", mem_err, 0);
      m_wait = 0; m_wcnt = 0; m_err = 0; m_stalls = 0;
    end else begin
      chk("stall_count", stall_count, m_stalls);
      chk("mem_err", mem_err, m_err);
      hold = !dmem_ready && (m_wait || dmem_req);
      if (hold)              exp_ctl = 8'b00000001;
      else if (branch_taken) exp_ctl = 8'b11111110;
      else if (model_hazard()) exp_ctl = 8'b00111010;
      else                   exp_ctl = 8'b11111000;
      chk("ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble}, exp_ctl);
      chk("fwd_a", fwd_a, model_fwd(id_rs));
      chk("fwd_b", fwd_b, model_fwd(id_rt));
      if (hold) begin
        m_wait = 1;
        m_wcnt++;
        if (TO > 0 && m_wcnt >= TO) m_err = 1;
      end else begin
        m_wait = 0;
        m_wcnt = 0;
      end
      if (!exp_ctl[7] && m_stalls < (1 << SW) - 1) m_stalls++;
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    smp();
    chk("lit_rst_pc", pc_en, 0);
    chk("lit_rst_iff", ifid_flush, 1);
    chk("lit_rst_bub", memwb_bubble, 1);
    chk("lit_rst_stall", stall_count, 0);
    cyc(); rst_n = 1'b1;
    smp(); chk("lit_run_pc", pc_en, 1);

    cyc(); ex_mem_to_reg = 1; ex_rd = 5; id_rs = 5;
    smp();
    chk("lit_lu_pc", pc_en, 0);
    chk("lit_lu_ifid", ifid_en, 0);
    chk("lit_lu_idexf", idex_flush, 1);
    chk("lit_lu_idex_en", idex_en, 1);
    chk("lit_lu_stall0", stall_count, 0);
    cyc(); idle();
    smp();
    chk("lit_lu_stall1", stall_count, 1);
    chk("lit_lu_release", pc_en, 1);

    cyc(); ex_mem_to_reg = 1; ex_rd = 5; id_rs = 5; branch_taken = 1;
    smp();
    chk("lit_br_iff", ifid_flush, 1);
    chk("lit_br_idf", idex_flush, 1);
    chk("lit_br_pc", pc_en, 1);
    cyc(); idle();
    smp(); chk("lit_br_stall", stall_count, 1);

    cyc(); dmem_req = 1; dmem_ready = 0;
    smp(); chk("lit_mw_pc1", pc_en, 0); chk("lit_mw_bub", memwb_bubble, 1);
    cyc(); smp(); chk("lit_mw_pc2", pc_en, 0);
    cyc(); smp(); chk("lit_mw_pc3", pc_en, 0);
    cyc(); dmem_ready = 1;
    smp(); chk("lit_mw_rel", pc_en, 1); chk("lit_mw_rel_bub", memwb_bubble, 0);
    cyc(); idle();
    smp(); chk("lit_mw_stall", stall_count, 4); chk("lit_mw_run", pc_en, 1);

    cyc(); dmem_req = 1; dmem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) cyc();
      smp();
      if (k == 4) chk("lit_to_before", mem_err, 0);
      if (k >= 5) chk("lit_to_set", mem_err, 1);
    end
    cyc(); dmem_ready = 1;
    smp(); chk("lit_to_rel", pc_en, 1); chk("lit_to_err_hold", mem_err, 1);
    cyc(); idle();
    smp(); chk("lit_to_stall", stall_count, 10); chk("lit_to_sticky", mem_err, 1);
    cyc(); rst_n = 1'b0;
    smp(); chk("lit_to_rst_err", mem_err, 0); chk("lit_to_rst_stall", stall_count, 0);
    cyc(); rst_n = 1'b1;

    cyc(); dmem_req = 1; dmem_ready = 0;
    smp(); chk("lit_ab_wait", pc_en, 0);
    cyc(); rst_n = 1'b0;
    smp(); chk("lit_ab_rst", pc_en, 0);
    cyc(); rst_n = 1'b1; dmem_req = 0;
    smp(); chk("lit_ab_run", pc_en, 1);

`ifdef PIPELINE_HAZARD_CTRL_FORWARD_EN
    cyc(); idle(); mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; id_rs = 7;
    smp(); chk("lit_fwd_exmem", fwd_a, 2'b10);
    cyc(); mem_reg_write = 0;
    smp(); chk("lit_fwd_memwb", fwd_a, 2'b01);
    cyc(); id_rs = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1;
    smp(); chk("lit_fwd_r0", fwd_a, 2'b00);
    cyc(); idle(); ex_reg_write = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
    smp(); chk("lit_fwd_nostall", pc_en, 1);
`else
    cyc(); idle(); ex_reg_write = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
    smp(); chk("lit_nf_pc", pc_en, 0); chk("lit_nf_idf", idex_flush, 1); chk("lit_nf_fwdb", fwd_b, 2'b00);
    cyc();
    smp(); chk("lit_nf_repeat", pc_en, 0);
    cyc(); ex_rd = 4;
    smp(); chk("lit_nf_release", pc_en, 1);
`endif

    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n         = ($urandom_range(0, 199) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_to_reg = ($urandom_range(0, 2) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 6) == 0);
      dmem_req      = ($urandom_range(0, 4) == 0);
      dmem_ready    = ($urandom_range(0, 9) < 5);
    end

    cyc(); rst_n = 1'b1; idle();
    smp();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
